dw_addsub_dx_acc: RTL and testbench
===================================

DW_ADDSUB_DX_ACC -- requirements
Module: dw_addsub_dx_acc

Interface
REQ-001 SHALL have parameter width, default 24: operand and accumulator width, legal range 4..64.
REQ-002 SHALL have parameter p1_width, default 8: lower-partition width in duplex mode, legal range 2..width-2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1: the block can accept an operand beat.
REQ-007 SHALL have port in_data, input, width: operand b.
REQ-008 SHALL have port in_last, input, 1: final beat of a run; triggers a dump after accumulation.
REQ-009 SHALL have ports addsub, tc, sat, dplx, inputs, 1 each: per-beat controls, 0=add/1=sub, 1=two's complement, 1=saturate, 1=duplex; sampled with the beat.
REQ-010 SHALL have port clr, input, 1: synchronous accumulator clear.
REQ-011 SHALL have port out_valid, output, 1: dump result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the dump.
REQ-013 SHALL have port out_acc, output, width: dumped accumulator value.
REQ-014 SHALL have ports out_co1, out_co2, outputs, 1 each: carry of the lower partition and of the upper/full partition from the last beat.
REQ-015 SHALL have ports out_ovf1, out_ovf2, outputs, 1 each: sticky overflow flags for the lower and upper/full partitions over the run.

Function
REQ-016 SHALL have two states: ACCUM and HOLD.
REQ-017 SHALL accept a beat when in_valid && in_ready; in_ready = (state==ACCUM).
REQ-018 On an accepted beat, SHALL update acc <= acc op in_data one cycle later, where op is + for addsub=0 and - for addsub=1 (subtract = acc + ~b + 1).
REQ-019 With dplx=0, SHALL treat all width bits as one operand; co1 = 0; co2 = carry out of bit width-1.
REQ-020 With dplx=1, SHALL compute bits [p1_width-1:0] and [width-1:p1_width] independently with no carry between partitions; co1 and co2 are the respective partition carries.
REQ-021 SHALL detect overflow per partition: unsigned (tc=0) on carry-out for add or borrow for sub; signed (tc=1) on sign mismatch of the operands versus the result.
REQ-022 With sat=1 and overflow, SHALL clamp the partition: unsigned to all-ones on add or zero on sub; signed to max-positive or min-negative per the operand sign; with sat=0, SHALL wrap.
REQ-023 SHALL set ovf1/ovf2 on any overflow in the run, regardless of sat, and hold them until the next dump handshake or clr.
REQ-024 On an accepted beat with in_last=1, SHALL go to HOLD on the same edge that updates acc; in the next cycle out_valid=1 and out_acc equals the final value.
REQ-025 In HOLD, SHALL hold out_acc, co and ovf stable until out_valid && out_ready; on that edge SHALL clear acc and ovf and return to ACCUM.
REQ-026 clr in ACCUM SHALL zero acc and ovf on the next edge; if a beat is accepted in the same cycle, SHALL apply the beat to zero (clear first).
REQ-027 clr in HOLD SHALL be ignored.
REQ-028 Beats SHALL be accepted back-to-back every cycle in ACCUM; throughput is 1 beat per clock.
REQ-029 out_acc SHALL track acc continuously; out_valid qualifies it.

Reset
REQ-030 rst=1 SHALL asynchronously force state=ACCUM, acc=0, out_valid=0, out_co1=out_co2=0, out_ovf1=out_ovf2=0, so in_ready=1 while in reset.
REQ-031 rst asserted mid-run or in HOLD SHALL discard the pending result; no dump is emitted after release.

Structure
REQ-032 SHALL place the state enum and the clamp-select encoding in the shared package dw_addsub_dx_pkg.
REQ-033 SHALL isolate the combinational partitioned add/sub, overflow and saturation logic in one sub-module, dw_addsub_dx_acc_core; the top holds the FSM, registers and handshakes.

Verification (width=24, p1_width=8)
REQ-034 Unsigned full add: beats 0x000010 then 0x000020 with last -> out_acc=0x000030, ovf2=0, out_valid held until out_ready.
REQ-035 Duplex wrap: dplx=1, sat=0, beats 0x0000F0 then 0x000020 with last -> out_acc=0x000010, co1=1, co2=0, ovf1=1, no carry into bit 8.
REQ-036 Signed saturate: tc=1, sat=1, beats 0x7FFFF0 then 0x000020 with last -> out_acc=0x7FFFFF, ovf2=1.
REQ-037 Backpressure: last beat accepted, out_ready=0 for 5 cycles -> in_ready=0 and out_acc stable; out_ready=1 -> ACCUM with acc=0 next cycle.
REQ-038 clr with a simultaneous beat 0x000005 after acc=0x000100 -> acc=0x000005.
REQ-039 rst pulse in HOLD -> out_valid=0 immediately, acc=0, in_ready=1.

Source files
------------

// File: rtl/dw_addsub_dx_pkg.sv
// Shared types for the duplex add/sub accumulator:
// FSM state, partition clamp selection and the per-partition overflow rule.
package dw_addsub_dx_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CLAMP_NONE,
    CLAMP_ONES,
    CLAMP_ZERO,
    CLAMP_MAXP,
    CLAMP_MINN
  } clamp_e;

  // bm is the sign of the effective addend (b, or ~b for subtract),
  // so one rule covers signed add and subtract.
  function automatic logic part_ovf(
    input logic tc,
    input logic sub,
    input logic co,
    input logic am,
    input logic bm,
    input logic rm
  );
    if (tc)
      return (am == bm) && (rm != am);
    return co ^ sub;
  endfunction

  // Signed clamp direction follows the accumulator sign, which on
  // overflow equals the effective addend sign.
  function automatic clamp_e clamp_sel(
    input logic ovf,
    input logic sat,
    input logic tc,
    input logic sub,
    input logic am
  );
    if (!(ovf && sat))
      return CLAMP_NONE;
    if (!tc)
      return sub ? CLAMP_ZERO : CLAMP_ONES;
    return am ? CLAMP_MINN : CLAMP_MAXP;
  endfunction

endpackage

// File: rtl/dw_addsub_dx_acc_if.sv
// Operand/dump bus of the duplex accumulator.
// master drives beats and out_ready; slave is the accumulator.
interface dw_addsub_dx_acc_if #(
  parameter int width = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             in_last;
  logic             addsub;
  logic             tc;
  logic             sat;
  logic             dplx;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_acc;
  logic             out_co1;
  logic             out_co2;
  logic             out_ovf1;
  logic             out_ovf2;

  modport master (
    output in_valid, in_data, in_last,
    output addsub, tc, sat, dplx, clr,
    output out_ready,
    input  in_ready, out_valid, out_acc,
    input  out_co1, out_co2, out_ovf1, out_ovf2
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  addsub, tc, sat, dplx, clr,
    input  out_ready,
    output in_ready, out_valid, out_acc,
    output out_co1, out_co2, out_ovf1, out_ovf2
  );
endinterface

// File: rtl/dw_addsub_dx_acc_core.sv
// Combinational partitioned add/sub with overflow and saturation.
// a,b in; res, per-partition carry (co1/co2) and overflow (ovf1/ovf2) out.
module dw_addsub_dx_acc_core
  import dw_addsub_dx_pkg::*;
#(
  parameter int width    = 24,
  parameter int p1_width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             sub,
  input  logic             tc,
  input  logic             sat,
  input  logic             dplx,
  output logic [width-1:0] res,
  output logic             co1,
  output logic             co2,
  output logic             ovf1,
  output logic             ovf2
);

  localparam int UW = width - p1_width;
  localparam int LW = p1_width + 1;
  localparam int HW = UW + 1;
  localparam int FW = width + 1;

  localparam logic [width-1:0] LO_MASK =
    {{UW{1'b0}}, {p1_width{1'b1}}};
  localparam logic [width-1:0] HI_MASK = ~LO_MASK;
  localparam logic [width-1:0] FU_MASK = '1;
  localparam logic [width-1:0] LO_MSB =
    {{(width-1){1'b0}}, 1'b1} << (p1_width - 1);
  localparam logic [width-1:0] HI_MSB =
    {1'b1, {(width-1){1'b0}}};

  // Partition results are kept in their final bit positions so one
  // clamp helper serves the lower, upper and full-width cases.
  function automatic logic [width-1:0] pick(
    input clamp_e           c,
    input logic [width-1:0] s,
    input logic [width-1:0] mask,
    input logic [width-1:0] msb
  );
    case (c)
      CLAMP_ONES: return mask;
      CLAMP_ZERO: return '0;
      CLAMP_MAXP: return mask & ~msb;
      CLAMP_MINN: return msb;
      default:    return s & mask;
    endcase
  endfunction

  logic [width-1:0] bx;
  logic [LW-1:0]    lo_sum;
  logic [HW-1:0]    hi_sum;
  logic [FW-1:0]    fu_sum;
  logic [width-1:0] lo_pos;
  logic [width-1:0] hi_pos;
  logic             ov_lo;
  logic             ov_hi;
  logic             ov_fu;
  clamp_e           cs_lo;
  clamp_e           cs_hi;
  clamp_e           cs_fu;

  assign bx = sub ? ~b : b;

  assign lo_sum = {1'b0, a[p1_width-1:0]}
                + {1'b0, bx[p1_width-1:0]}
                + LW'(sub);
  assign hi_sum = {1'b0, a[width-1:p1_width]}
                + {1'b0, bx[width-1:p1_width]}
                + HW'(sub);
  assign fu_sum = {1'b0, a} + {1'b0, bx} + FW'(sub);

  assign lo_pos = {{UW{1'b0}}, lo_sum[p1_width-1:0]};
  assign hi_pos = {hi_sum[UW-1:0], {p1_width{1'b0}}};

  always_comb begin
    ov_lo = part_ovf(tc, sub, lo_sum[p1_width],
                     a[p1_width-1], bx[p1_width-1],
                     lo_sum[p1_width-1]);
    ov_hi = part_ovf(tc, sub, hi_sum[UW],
                     a[width-1], bx[width-1],
                     hi_sum[UW-1]);
    ov_fu = part_ovf(tc, sub, fu_sum[width],
                     a[width-1], bx[width-1],
                     fu_sum[width-1]);

    cs_lo = clamp_sel(ov_lo, sat, tc, sub, a[p1_width-1]);
    cs_hi = clamp_sel(ov_hi, sat, tc, sub, a[width-1]);
    cs_fu = clamp_sel(ov_fu, sat, tc, sub, a[width-1]);

    if (dplx) begin
      res  = pick(cs_lo, lo_pos, LO_MASK, LO_MSB)
           | pick(cs_hi, hi_pos, HI_MASK, HI_MSB);
      co1  = lo_sum[p1_width];
      co2  = hi_sum[UW];
      ovf1 = ov_lo;
      ovf2 = ov_hi;
    end else begin
      res  = pick(cs_fu, fu_sum[width-1:0], FU_MASK, HI_MSB);
      co1  = 1'b0;
      co2  = fu_sum[width];
      ovf1 = 1'b0;
      ovf2 = ov_fu;
    end
  end

endmodule

// File: rtl/dw_addsub_dx_acc.sv
// Duplex add/sub accumulator: beats in via bus, dump on in_last.
// Ports: clk, rst (async, active-high), bus (slave modport).
module dw_addsub_dx_acc
  import dw_addsub_dx_pkg::*;
#(
  parameter int width    = 24,
  parameter int p1_width = 8
) (
  input  logic                clk,
  input  logic                rst,
  dw_addsub_dx_acc_if.slave   bus
);

  state_e           state_q, state_d;
  logic [width-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             co1_q, co1_d;
  logic             co2_q, co2_d;
  logic             ovf1_q, ovf1_d;
  logic             ovf2_q, ovf2_d;

  logic [width-1:0] acc_base;
  logic             ovf1_base;
  logic             ovf2_base;
  logic [width-1:0] core_res;
  logic             core_co1;
  logic             core_co2;
  logic             core_ovf1;
  logic             core_ovf2;

  dw_addsub_dx_acc_core #(
    .width   (width),
    .p1_width(p1_width)
  ) u_core (
    .a   (acc_base),
    .b   (bus.in_data),
    .sub (bus.addsub),
    .tc  (bus.tc),
    .sat (bus.sat),
    .dplx(bus.dplx),
    .res (core_res),
    .co1 (core_co1),
    .co2 (core_co2),
    .ovf1(core_ovf1),
    .ovf2(core_ovf2)
  );

  always_comb begin
    // clr is applied ahead of a same-cycle beat
    acc_base  = acc_q;
    ovf1_base = ovf1_q;
    ovf2_base = ovf2_q;
    if (state_q == ACCUM && bus.clr) begin
      acc_base  = '0;
      ovf1_base = 1'b0;
      ovf2_base = 1'b0;
    end

    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    co1_d       = co1_q;
    co2_d       = co2_q;
    ovf1_d      = ovf1_q;
    ovf2_d      = ovf2_q;

    case (state_q)
      ACCUM: begin
        acc_d  = acc_base;
        ovf1_d = ovf1_base;
        ovf2_d = ovf2_base;
        if (bus.in_valid) begin
          acc_d  = core_res;
          co1_d  = core_co1;
          co2_d  = core_co2;
          ovf1_d = ovf1_base | core_ovf1;
          ovf2_d = ovf2_base | core_ovf2;
          if (bus.in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          ovf1_d      = 1'b0;
          ovf2_d      = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      co1_q       <= 1'b0;
      co2_q       <= 1'b0;
      ovf1_q      <= 1'b0;
      ovf2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      co1_q       <= co1_d;
      co2_q       <= co2_d;
      ovf1_q      <= ovf1_d;
      ovf2_q      <= ovf2_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_co1   = co1_q;
  assign bus.out_co2   = co2_q;
  assign bus.out_ovf1  = ovf1_q;
  assign bus.out_ovf2  = ovf2_q;

endmodule

// File: tb/tb_dw_addsub_dx_acc.sv
// Directed bench for dw_addsub_dx_acc (width=24, p1_width=8).
module tb_dw_addsub_dx_acc;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dw_addsub_dx_acc_if #(.width(W)) bus ();

  dw_addsub_dx_acc #(
    .width   (W),
    .p1_width(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.addsub    = 1'b0;
    bus.tc        = 1'b0;
    bus.sat       = 1'b0;
    bus.dplx      = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d,
                      input logic sub, input logic tc,
                      input logic sat, input logic dplx,
                      input logic last, input logic clr);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.addsub   = sub;
    bus.tc       = tc;
    bus.sat      = sat;
    bus.dplx     = dplx;
    bus.in_last  = last;
    bus.clr      = clr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.clr      = 1'b0;
  endtask

  task automatic dump_chk(input string tag,
                          input logic [W-1:0] acc,
                          input logic co1, input logic co2,
                          input logic o1, input logic o2);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, ".acc"},   64'(bus.out_acc), 64'(acc));
    chk({tag, ".co1"},   64'(bus.out_co1), 64'(co1));
    chk({tag, ".co2"},   64'(bus.out_co2), 64'(co2));
    chk({tag, ".ovf1"},  64'(bus.out_ovf1), 64'(o1));
    chk({tag, ".ovf2"},  64'(bus.out_ovf2), 64'(o2));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".dr_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".dr_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".dr_acc"},   64'(bus.out_acc), 64'd0);
    chk({tag, ".dr_ovf1"},  64'(bus.out_ovf1), 64'd0);
    chk({tag, ".dr_ovf2"},  64'(bus.out_ovf2), 64'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst.ready", 64'(bus.in_ready), 64'd1);
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.acc",   64'(bus.out_acc), 64'd0);
    chk("rst.ovf",   64'({bus.out_ovf1, bus.out_ovf2}), 64'd0);
    chk("rst.co",    64'({bus.out_co1, bus.out_co2}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // unsigned full add, output held while out_ready low
    beat(24'h000010, 0, 0, 0, 0, 0, 0);
    chk("add.track", 64'(bus.out_acc), 64'h10);
    chk("add.nvalid", 64'(bus.out_valid), 64'd0);
    beat(24'h000020, 0, 0, 0, 0, 1, 0);
    dump_chk("add", 24'h000030, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("add.held", 64'(bus.out_valid), 64'd1);
    drain("add");

    // duplex wrap: no carry from bit 7 into bit 8
    beat(24'h0000F0, 0, 0, 0, 1, 0, 0);
    beat(24'h000020, 0, 0, 0, 1, 1, 0);
    dump_chk("dpx", 24'h000010, 1, 0, 1, 0);
    drain("dpx");

    // ovf sticky across a later clean beat; co from last beat
    beat(24'h0000F0, 0, 0, 0, 1, 0, 0);
    beat(24'h000020, 0, 0, 0, 1, 0, 0);
    beat(24'h000001, 0, 0, 0, 1, 1, 0);
    dump_chk("sticky", 24'h000011, 0, 0, 1, 0);
    drain("sticky");

    // signed saturate to max positive
    beat(24'h7FFFF0, 0, 1, 1, 0, 0, 0);
    beat(24'h000020, 0, 1, 1, 0, 1, 0);
    dump_chk("ssat", 24'h7FFFFF, 0, 0, 0, 1);
    drain("ssat");

    // signed subtract saturates to min negative
    beat(24'h800010, 0, 1, 1, 0, 0, 0);
    beat(24'h000020, 1, 1, 1, 0, 1, 0);
    dump_chk("ssub", 24'h800000, 0, 1, 0, 1);
    drain("ssub");

    // unsigned subtract borrow clamps to zero
    beat(24'h000010, 0, 0, 1, 0, 0, 0);
    beat(24'h000020, 1, 0, 1, 0, 1, 0);
    dump_chk("usub", 24'h000000, 0, 0, 0, 1);
    drain("usub");

    // duplex unsigned saturate both partitions
    beat(24'hFF00F0, 0, 0, 1, 1, 0, 0);
    beat(24'h020020, 0, 0, 1, 1, 1, 0);
    dump_chk("dsat", 24'hFFFFFF, 1, 1, 1, 1);
    drain("dsat");

    // backpressure; beats and clr during HOLD are ignored
    beat(24'h000123, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 24'h000007;
      bus.clr      = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.ready", 64'(bus.in_ready), 64'd0);
      chk("bp.acc",   64'(bus.out_acc), 64'h123);
    end
    idle();
    drain("bp");

    // clr with simultaneous beat applies beat to zero
    beat(24'h000100, 0, 0, 0, 0, 0, 0);
    chk("clr.pre", 64'(bus.out_acc), 64'h100);
    beat(24'h000005, 0, 0, 0, 0, 1, 1);
    dump_chk("clr", 24'h000005, 0, 0, 0, 0);
    drain("clr");

    // clr alone zeroes the accumulator
    beat(24'h000040, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    chk("clr0.acc", 64'(bus.out_acc), 64'd0);

    // reset in HOLD discards the pending dump
    beat(24'h000055, 0, 0, 0, 0, 1, 0);
    chk("rsth.pre", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rsth.valid", 64'(bus.out_valid), 64'd0);
    chk("rsth.acc",   64'(bus.out_acc), 64'd0);
    chk("rsth.ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rsth.post", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
